// File: rtl/text_overlay_engine.sv
//------------------------------------------------------------------------------
// text_overlay_engine : character-cell BCD clock/timer overlay with edit cursor
//   and alarm indicator (indicator + ring FSM built only with ALARM_FLASH_EN).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module text_overlay_engine #(
  parameter int NUM_FIELDS     = 9,
  parameter int FIELDS_PER_ROW = 3,
  parameter int SCALE_LOG2     = 2,
  parameter int BLINK_DIV      = 50_000_000,
  parameter int ALARM_COL      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    video_on_i,
  input  logic [8*NUM_FIELDS-1:0] digits_i,
  input  logic [3:0]              sel_i,
  input  logic                    cursor_en_i,
  input  logic                    alarm_i,
  input  logic                    alarm_ack_i,
  output logic [10:0]             font_addr_o,
  input  logic [7:0]              font_word_i,
  output logic                    text_on_o,
  output logic [2:0]              text_rgb_o
);

  localparam int         S        = SCALE_LOG2;
  localparam int         CNT_W    = $clog2(BLINK_DIV);
  localparam int         NUM_ROWS = (NUM_FIELDS + FIELDS_PER_ROW - 1) / FIELDS_PER_ROW;
  localparam logic [9:0] IND_ROW  = 10'(2 * NUM_ROWS);
  localparam logic [9:0] IND_COL  = 10'(ALARM_COL);

  typedef struct packed {
    logic       von;
    logic       glyph;
    logic [2:0] bg;
    logic [2:0] bit_idx;
    logic       ind;
    logic [2:0] ind_rgb;
  } attr_t;

  function automatic logic [6:0] bcd_char(input logic [3:0] d);
    return (d > 4'd9) ? 7'h3F : {3'b011, d};
  endfunction

  // Free-running blink timebase, independent of the raster position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    blink_d = blink_q;
    if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

`ifdef ALARM_FLASH_EN
  typedef enum logic [1:0] {
    RING_IDLE    = 2'd0,
    RING_RINGING = 2'd1,
    RING_ACKED   = 2'd2
  } ring_state_e;

  ring_state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RING_IDLE;
    else         state_q <= state_d;
  end

  // Dropping the alarm takes priority over an acknowledge in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      RING_IDLE:    if (alarm_i && !alarm_ack_i) state_d = RING_RINGING;
      RING_RINGING: begin
        if (!alarm_i)         state_d = RING_IDLE;
        else if (alarm_ack_i) state_d = RING_ACKED;
      end
      RING_ACKED:   if (!alarm_i) state_d = RING_IDLE;
      default:      state_d = RING_IDLE;
    endcase
  end
`else
  logic unused_alarm;
  assign unused_alarm = alarm_i ^ alarm_ack_i;
`endif

  // S0: cell decode
  logic [9:0]  cx, cy;
  logic [6:0]  char_d;
  attr_t       s1_d, s1_q, s2_d, s2_q;
  logic [10:0] font_addr_d, font_addr_q;

  assign cx = pix_x >> (3 + S);
  assign cy = pix_y >> (4 + S);

  always_comb begin
    char_d       = 7'h00;
    s1_d         = '0;
    s1_d.von     = video_on_i;
    s1_d.bit_idx = pix_x[2+S:S];
    for (int f = 0; f < NUM_FIELDS; f++) begin
      if (cy == 10'(2 * (f / FIELDS_PER_ROW) + 1)) begin
        if (cx == 10'(2 + 3 * (f % FIELDS_PER_ROW))) begin
          char_d     = bcd_char(digits_i[8*f+4 +: 4]);
          s1_d.glyph = 1'b1;
          if (cursor_en_i && (sel_i == 4'(f)) && blink_q) s1_d.bg = 3'b101;
        end else if (cx == 10'(3 + 3 * (f % FIELDS_PER_ROW))) begin
          char_d     = bcd_char(digits_i[8*f +: 4]);
          s1_d.glyph = 1'b1;
          if (cursor_en_i && (sel_i == 4'(f)) && blink_q) s1_d.bg = 3'b101;
        end else if ((cx == 10'(4 + 3 * (f % FIELDS_PER_ROW))) &&
                     ((f % FIELDS_PER_ROW) != FIELDS_PER_ROW - 1) &&
                     (f != NUM_FIELDS - 1)) begin
          char_d     = 7'h3A;
          s1_d.glyph = 1'b1;
        end
      end
    end
`ifdef ALARM_FLASH_EN
    if ((cy == IND_ROW) && (cx == IND_COL)) begin
      s1_d.ind     = 1'b1;
      s1_d.ind_rgb = (state_q == RING_RINGING) ? (blink_q ? 3'b010 : 3'b100) : 3'b110;
    end
`endif
  end

  always_comb begin
    font_addr_d = {char_d, pix_y[3+S:S]};
    s2_d        = s1_q;
  end

  // S1 holds the ROM address; S2 lines the attributes up with the ROM data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      font_addr_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
    end else begin
      font_addr_q <= font_addr_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end

  assign font_addr_o = font_addr_q;

  // S2: pixel select
  logic px;
  always_comb begin
    px         = font_word_i[3'd7 - s2_q.bit_idx];
    text_on_o  = 1'b0;
    text_rgb_o = 3'b000;
    if (s2_q.von) begin
      if (s2_q.ind) begin
        text_on_o  = 1'b1;
        text_rgb_o = s2_q.ind_rgb;
      end else if (s2_q.glyph) begin
        if (px) begin
          text_on_o  = 1'b1;
          text_rgb_o = 3'b100;
        end else if (s2_q.bg != 3'b000) begin
          text_on_o  = 1'b1;
          text_rgb_o = s2_q.bg;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_overlay_engine.sv
//------------------------------------------------------------------------------
// tb_text_overlay_engine : directed self-checking bench for text_overlay_engine.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_text_overlay_engine;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RING = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x, pix_y;
  logic        video_on;
  logic [71:0] digits;
  logic [3:0]  sel;
  logic        cursor_en, alarm, ack;
  logic [10:0] font_addr;
  logic [7:0]  font_word;
  logic        text_on;
  logic [2:0]  text_rgb;

  int n_checks = 0;
  int n_pass   = 0;
  int rom_mode = 0;

  logic [1:0] m_cnt;
  logic       m_blink;

  always #5 clk = ~clk;

  text_overlay_engine #(
    .NUM_FIELDS    (9),
    .FIELDS_PER_ROW(3),
    .SCALE_LOG2    (2),
    .BLINK_DIV     (4),
    .ALARM_COL     (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .video_on_i (video_on),
    .digits_i   (digits),
    .sel_i      (sel),
    .cursor_en_i(cursor_en),
    .alarm_i    (alarm),
    .alarm_ack_i(ack),
    .font_addr_o(font_addr),
    .font_word_i(font_word),
    .text_on_o  (text_on),
    .text_rgb_o (text_rgb)
  );

  function automatic logic [7:0] rom_fn(input logic [10:0] a, input int mode);
    if (mode == 1) return 8'h00;
    if (mode == 2) return 8'hFF;
    return {a[3:0], a[7:4]} ^ {1'b1, a[10:8], 4'h5};
  endfunction

  // Synchronous font ROM, one cycle of read latency
  always @(posedge clk) font_word <= rom_fn(font_addr, rom_mode);

  // Reference blink timebase (BLINK_DIV = 4)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 2'd0;
      m_blink <= 1'b0;
    end else if (m_cnt == 2'd3) begin
      m_cnt   <= 2'd0;
      m_blink <= ~m_blink;
    end else begin
      m_cnt <= m_cnt + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one pixel for one clock, then move away; checks address at +1, colour at +2
  task automatic probe(input string tag, input int x, input int y, input logic [6:0] ch,
                       input logic glyph, input logic cur, input logic ind, input logic [1:0] st);
    logic        b, von, px, e_on;
    logic [10:0] a;
    logic [7:0]  w;
    logic [2:0]  xb, bg, e_rgb;
    @(posedge clk); #1;
    pix_x = 10'(x);
    pix_y = 10'(y);
    b     = m_blink;
    von   = video_on;
    a     = {ch, pix_y[5:2]};
    xb    = pix_x[4:2];
    @(posedge clk); #1;
    pix_x = 10'd0;
    pix_y = 10'd0;
    check({tag, ".addr"}, 32'(font_addr), 32'(a));
    @(posedge clk); #1;
    w     = rom_fn(a, rom_mode);
    px    = w[3'd7 - xb];
    e_on  = 1'b0;
    e_rgb = 3'b000;
    if (von) begin
      if (ind) begin
        e_on  = 1'b1;
        e_rgb = (st == ST_RING) ? (b ? 3'b010 : 3'b100) : 3'b110;
      end else if (glyph) begin
        bg = (cur && b) ? 3'b101 : 3'b000;
        if (px) begin
          e_on  = 1'b1;
          e_rgb = 3'b100;
        end else if (bg != 3'b000) begin
          e_on  = 1'b1;
          e_rgb = bg;
        end
      end
    end
    check({tag, ".rgb"}, 32'(text_rgb), 32'(e_rgb));
    check({tag, ".on"},  32'(text_on),  32'(e_on));
  endtask

  logic bm1, bm2;

  initial begin
    rst_n     = 1'b0;
    pix_x     = 10'd0;
    pix_y     = 10'd0;
    video_on  = 1'b1;
    digits    = {8'hF6, 8'h31, 8'h99, 8'h00, 8'h8A, 8'h03, 8'h59, 8'h12, 8'h47};
    sel       = 4'hF;
    cursor_en = 1'b0;
    alarm     = 1'b0;
    ack       = 1'b0;

    // Reset held with a wandering raster
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pix_x = 10'($urandom_range(0, 639));
      pix_y = 10'($urandom_range(0, 479));
      #3;
      check("rst.rgb",  32'(text_rgb),  32'd0);
      check("rst.on",   32'(text_on),   32'd0);
      check("rst.addr", 32'(font_addr), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Digit, colon and boundary cells
    probe("f0.tens",    64,  64,  7'h34, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f0.tens.b3", 76,  84,  7'h34, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f0.units",   124, 124, 7'h37, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f0.colon",   128, 72,  7'h3A, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f2.units",   288, 64,  7'h39, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f4.units",   196, 192, 7'h3F, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f7.colon",   224, 320, 7'h3A, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f8.tens",    256, 320, 7'h3F, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f8.units",   304, 320, 7'h36, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("f8.nocolon", 320, 320, 7'h00, 1'b0, 1'b0, 1'b0, ST_IDLE);
    probe("margin",     32,  64,  7'h00, 1'b0, 1'b0, 1'b0, ST_IDLE);
    probe("gaprow",     64,  128, 7'h00, 1'b0, 1'b0, 1'b0, ST_IDLE);

    // Cursor blink on field 1 with blank glyph rows
    rom_mode  = 1;
    cursor_en = 1'b1;
    sel       = 4'd1;
    for (int i = 0; i < 6; i++) probe("cur.f1", 160, 64, 7'h31, 1'b1, 1'b1, 1'b0, ST_IDLE);
    probe("cur.f0", 64, 64, 7'h34, 1'b1, 1'b0, 1'b0, ST_IDLE);
    probe("cur.f0", 64, 64, 7'h34, 1'b1, 1'b0, 1'b0, ST_IDLE);

    @(posedge clk); #1;
    pix_x = 10'd160;
    pix_y = 10'd64;
    bm2   = m_blink;
    @(posedge clk); #1;
    bm1   = m_blink;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      check("stream.rgb", 32'(text_rgb), bm2 ? 32'd5 : 32'd0);
      check("stream.on",  32'(text_on),  bm2 ? 32'd1 : 32'd0);
      bm2 = bm1;
      bm1 = m_blink;
    end

    sel = 4'hF;
    for (int i = 0; i < 3; i++) probe("nosel", 160, 64, 7'h31, 1'b1, 1'b0, 1'b0, ST_IDLE);
    sel = 4'd9;
    for (int i = 0; i < 3; i++) probe("sel9", 160, 64, 7'h31, 1'b1, 1'b0, 1'b0, ST_IDLE);
    sel       = 4'd1;
    cursor_en = 1'b0;
    for (int i = 0; i < 3; i++) probe("curoff", 160, 64, 7'h31, 1'b1, 1'b0, 1'b0, ST_IDLE);
    rom_mode = 0;

    // Alarm indicator at char (4,6)
`ifdef ALARM_FLASH_EN
    probe("ind.idle", 136, 388, 7'h00, 1'b0, 1'b0, 1'b1, ST_IDLE);
    @(posedge clk); #1 alarm = 1'b1;
    for (int i = 0; i < 4; i++) probe("ind.ring", 136, 388, 7'h00, 1'b0, 1'b0, 1'b1, ST_RING);
    @(posedge clk); #1 ack = 1'b1;
    probe("ind.ack", 136, 388, 7'h00, 1'b0, 1'b0, 1'b1, ST_ACK);
    @(posedge clk); #1 alarm = 1'b0;
    probe("ind.clr", 136, 388, 7'h00, 1'b0, 1'b0, 1'b1, ST_IDLE);
    @(posedge clk); #1 ack = 1'b0;
    @(posedge clk); #1 alarm = 1'b1;
    for (int i = 0; i < 3; i++) probe("ind.rering", 136, 388, 7'h00, 1'b0, 1'b0, 1'b1, ST_RING);
    @(posedge clk); #1;
    alarm = 1'b0;
    ack   = 1'b1;
    @(posedge clk); #1 alarm = 1'b1;
    probe("ind.clrwins", 136, 388, 7'h00, 1'b0, 1'b0, 1'b1, ST_IDLE);
    @(posedge clk); #1 ack = 1'b0;
    for (int i = 0; i < 3; i++) probe("ind.fromidle", 136, 388, 7'h00, 1'b0, 1'b0, 1'b1, ST_RING);
    @(posedge clk); #1 alarm = 1'b0;
`else
    @(posedge clk); #1 alarm = 1'b1;
    for (int i = 0; i < 3; i++) probe("ind.off", 136, 388, 7'h00, 1'b0, 1'b0, 1'b0, ST_IDLE);
    alarm = 1'b0;
`endif

    // Video blanking and mid-line reset on a lit digit pixel
    rom_mode = 2;
    probe("lit.von", 64, 64, 7'h34, 1'b1, 1'b0, 1'b0, ST_IDLE);
    video_on = 1'b0;
    probe("lit.voff", 64, 64, 7'h34, 1'b1, 1'b0, 1'b0, ST_IDLE);
    video_on = 1'b1;

    @(posedge clk); #1;
    pix_x = 10'd64;
    pix_y = 10'd64;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst.on", 32'(text_on), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.rgb",  32'(text_rgb),  32'd0);
    check("midrst.on",   32'(text_on),   32'd0);
    check("midrst.addr", 32'(font_addr), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst1.on", 32'(text_on), 32'd0);
    @(posedge clk); #1;
    check("post_rst2.on",  32'(text_on),  32'd1);
    check("post_rst2.rgb", 32'(text_rgb), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
